// File: rtl/squeeze_controller.sv
// SHAKE squeeze controller: streams rate lanes of the permuted Keccak state as a
// byte-length-limited output stream and requests permutations at block boundaries.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | accepting rate lanes into the output register
// PERM   | block consumed, waiting for the core to finish the next permutation
// FLUSH  | final word loaded, waiting for its downstream handshake
module squeeze_controller #(
    parameter int WIDTH         = 32,
    parameter int LANES_IN_RATE = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_output_byte_size,
    input  logic [63:0]      i_lane_data,
    input  logic             i_lane_valid,
    output logic             o_lane_ready,
    output logic             o_perm_req,
    input  logic             i_perm_done,
    output logic [63:0]      o_dout,
    output logic [7:0]       o_dout_keep,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_dout_last,
    output logic             o_busy,
    output logic             o_done
);
    localparam int LANE_W     = 64;
    localparam int BYTE_DELTA = LANE_W / 8;
    localparam int CNT_W      = $clog2(LANES_IN_RATE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_PERM   = 2'd2;
    localparam logic [1:0] S_FLUSH  = 2'd3;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_remaining;
    logic [CNT_W-1:0]  r_lane_cnt;
    logic [LANE_W-1:0] r_dout;
    logic [7:0]        r_dout_keep;
    logic              r_dout_valid;
    logic              r_dout_last;
    logic              r_perm_req;
    logic              r_done;

    logic              w_accept;
    logic              w_final_lane;
    logic              w_block_end;
    logic              w_drain;
    logic [7:0]        w_keep;
    logic [LANE_W-1:0] w_data;

    assign o_lane_ready = (r_state == S_STREAM) && (!r_dout_valid || i_dout_ready);
    assign w_accept     = i_lane_valid && o_lane_ready;
    assign w_drain      = r_dout_valid && i_dout_ready;
    assign w_final_lane = (r_remaining <= WIDTH'(BYTE_DELTA));
    assign w_block_end  = (r_lane_cnt == CNT_W'(LANES_IN_RATE - 1));

    // Byte i is kept while more than i bytes are still owed; for non-final lanes this is all ones.
    always_comb begin
        w_keep = '0;
        w_data = '0;
        for (int i = 0; i < BYTE_DELTA; i++) begin
            w_keep[i]       = (r_remaining > WIDTH'(i));
            w_data[8*i +: 8] = i_lane_data[8*i +: 8] & {8{w_keep[i]}};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_lane_cnt   <= '0;
            r_dout       <= '0;
            r_dout_keep  <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_perm_req   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_perm_req <= 1'b0;
            r_done     <= 1'b0;
            // Output register drains on its own; a new lane below overrides this.
            if (w_drain) begin
                r_dout_valid <= 1'b0;
                r_dout_last  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_output_byte_size == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_remaining <= i_output_byte_size;
                            r_lane_cnt  <= '0;
                            r_state     <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_accept) begin
                        r_dout       <= w_data;
                        r_dout_keep  <= w_keep;
                        r_dout_valid <= 1'b1;
                        if (w_final_lane) begin
                            r_dout_last <= 1'b1;
                            r_state     <= S_FLUSH;
                        end else begin
                            r_dout_last <= 1'b0;
                            r_remaining <= r_remaining - WIDTH'(BYTE_DELTA);
                            if (w_block_end) begin
                                r_lane_cnt <= '0;
                                r_perm_req <= 1'b1;
                                r_state    <= S_PERM;
                            end else begin
                                r_lane_cnt <= r_lane_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                S_PERM: begin
                    if (i_perm_done) begin
                        r_state <= S_STREAM;
                    end
                end
                S_FLUSH: begin
                    if (w_drain) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_perm_req   = r_perm_req;
    assign o_dout       = r_dout;
    assign o_dout_keep  = r_dout_keep;
    assign o_dout_valid = r_dout_valid;
    assign o_dout_last  = r_dout_last;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;

endmodule

// File: tb/tb_squeeze_controller.sv
// Directed bench for squeeze_controller: fixed output lengths, block boundaries,
// backpressure, zero length, start while busy and mid-stream reset.
module tb_squeeze_controller;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] out_size;
    logic [63:0]      lane_data;
    logic             lane_valid;
    logic             lane_ready;
    logic             perm_req;
    logic             perm_done;
    logic [63:0]      dout;
    logic [7:0]       dout_keep;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] q_dat[$];
    logic [7:0]  q_keep[$];
    logic        q_last[$];
    int          last_done_k;

    squeeze_controller #(.WIDTH(WIDTH), .LANES_IN_RATE(17)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_start            (start),
        .i_output_byte_size (out_size),
        .i_lane_data        (lane_data),
        .i_lane_valid       (lane_valid),
        .o_lane_ready       (lane_ready),
        .o_perm_req         (perm_req),
        .i_perm_done        (perm_done),
        .o_dout             (dout),
        .o_dout_keep        (dout_keep),
        .o_dout_valid       (dout_valid),
        .i_dout_ready       (dout_ready),
        .o_dout_last        (dout_last),
        .o_busy             (busy),
        .o_done             (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int j);
        logic [7:0] b;
        b = 8'(j);
        return 64'h8877665544332211 ^ {8{b}};
    endfunction

    function automatic logic [7:0] exp_keep(input int j, input int size);
        int nw;
        int rem;
        logic [8:0] k;
        nw = (size + 7) / 8;
        if (j < nw - 1) return 8'hFF;
        rem = size - 8 * (nw - 1);
        k = (9'd1 << rem) - 9'd1;
        return k[7:0];
    endfunction

    function automatic logic [63:0] apply_keep(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*i +: 8] & {8{k[i]}};
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, ":lane_ready"}, 64'(lane_ready), 0);
        check({tag, ":perm_req"},   64'(perm_req),   0);
        check({tag, ":dout"},       dout,            0);
        check({tag, ":dout_keep"},  64'(dout_keep),  0);
        check({tag, ":dout_valid"}, 64'(dout_valid), 0);
        check({tag, ":dout_last"},  64'(dout_last),  0);
        check({tag, ":busy"},       64'(busy),       0);
        check({tag, ":done"},       64'(done),       0);
    endtask

    task automatic run_case(input string name, input int size, input int exp_perm,
                            input bit bp, input bit poke_start);
        int k = 0, lane_idx = 0, pd_cnt = 0, perm_cnt = 0;
        int stall_err = 0, hold_err = 0, data_err = 0, bytes = 0;
        int last_k = -1, done_k = -1, nw;
        bit perm_wait = 0, stalled = 0, acc, busy_at_done = 1;
        logic [63:0] h_dout;
        logic [7:0]  h_keep;
        logic        h_last;
        nw = (size + 7) / 8;
        q_dat.delete(); q_keep.delete(); q_last.delete();
        @(posedge clk); #1;
        start = 1'b1;
        out_size = WIDTH'(size);
        @(posedge clk); #1;
        start = 1'b0;
        while (done_k < 0 && k < 2000) begin
            lane_valid = 1'b1;
            lane_data  = pat(lane_idx);
            dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            perm_done  = (pd_cnt == 1);
            if (pd_cnt > 0) pd_cnt--;
            if (poke_start && k == 1) begin
                start    = 1'b1;
                out_size = WIDTH'(999);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k == 0) begin
                check({name, ":busy_after_start"},  64'(busy), 1);
                check({name, ":ready_after_start"}, 64'(lane_ready), 1);
            end
            if (stalled && (dout !== h_dout || dout_keep !== h_keep ||
                            dout_last !== h_last || dout_valid !== 1'b1)) hold_err++;
            stalled = dout_valid && !dout_ready;
            h_dout = dout; h_keep = dout_keep; h_last = dout_last;
            if (perm_wait && lane_ready) stall_err++;
            if (perm_req) begin
                perm_cnt++;
                if (lane_ready) stall_err++;
                perm_wait = 1;
                pd_cnt = 3;
            end
            if (perm_wait && perm_done) perm_wait = 0;
            acc = lane_valid && lane_ready;
            if (dout_valid && dout_ready) begin
                q_dat.push_back(dout);
                q_keep.push_back(dout_keep);
                q_last.push_back(dout_last);
                if (dout_last) last_k = k;
            end
            if (done) begin
                done_k = k;
                busy_at_done = busy;
            end
            @(posedge clk); #1;
            if (acc) lane_idx++;
            k++;
        end
        lane_valid = 1'b0;
        perm_done  = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        check({name, ":timeout"},      64'(done_k >= 0), 1);
        check({name, ":done_pulse"},   64'(done), 0);
        check({name, ":idle_valid"},   64'(dout_valid), 0);
        check({name, ":busy_at_done"}, 64'(busy_at_done), 0);
        check({name, ":done_latency"}, 64'(done_k - last_k), 1);
        check({name, ":words"},        64'(q_dat.size()), 64'(nw));
        check({name, ":lanes_taken"},  64'(lane_idx), 64'(nw));
        for (int j = 0; j < q_dat.size(); j++) begin
            if (q_keep[j] !== exp_keep(j, size) ||
                q_dat[j] !== apply_keep(pat(j), exp_keep(j, size)) ||
                q_last[j] !== (j == nw - 1)) data_err++;
            bytes += $countones(q_keep[j]);
        end
        check({name, ":word_content"}, 64'(data_err), 0);
        check({name, ":byte_count"},   64'(bytes), 64'(size));
        check({name, ":perm_reqs"},    64'(perm_cnt), 64'(exp_perm));
        check({name, ":perm_stall"},   64'(stall_err), 0);
        check({name, ":bp_hold"},      64'(hold_err), 0);
        last_done_k = done_k;
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; start = 1'b0; out_size = '0; lane_data = '0;
        lane_valid = 1'b0; perm_done = 1'b0; dout_ready = 1'b0;
        #2;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_case("size16", 16, 0, 1'b0, 1'b0);
        check("size16:cycles", 64'(last_done_k), 3);
        check("size16:keep_w1", 64'(q_keep[0]), 64'hFF);
        check("size16:keep_w2", 64'(q_keep[1]), 64'hFF);

        run_case("size13", 13, 0, 1'b0, 1'b0);
        check("size13:keep_w2", 64'(q_keep[1]), 64'h1F);
        check("size13:data_w2", q_dat[1], 64'h0000005445322310);
        check("size13:last_w2", 64'(q_last[1]), 1);

        run_case("size200", 200, 1, 1'b0, 1'b0);
        check("size200:keep_final", 64'(q_keep[24]), 64'hFF);

        run_case("size136", 136, 0, 1'b0, 1'b0);
        check("size136:cycles", 64'(last_done_k), 18);

        run_case("size300_bp", 300, 2, 1'b1, 1'b0);
        check("size300_bp:keep_final", 64'(q_keep[37]), 64'h0F);

        run_case("busy_start", 16, 0, 1'b0, 1'b1);

        // Zero-length request completes without producing a word.
        @(posedge clk); #1;
        start = 1'b1; out_size = '0;
        @(negedge clk);
        check("zero:done_early", 64'(done), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero:done", 64'(done), 1);
        check("zero:busy", 64'(busy), 0);
        check("zero:valid", 64'(dout_valid), 0);
        @(negedge clk);
        check("zero:done_pulse", 64'(done), 0);

        // Reset in the middle of a stream.
        @(posedge clk); #1;
        start = 1'b1; out_size = WIDTH'(200);
        @(posedge clk); #1;
        start = 1'b0; lane_valid = 1'b1; lane_data = pat(0); dout_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst:streaming", 64'(dout_valid), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        lane_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("midrst:no_done", 64'(done_seen), 0);

        run_case("recover", 16, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/squeeze_controller.md
# squeeze_controller

Output-side counterpart of the SHAKE absorb padding path. Accepts rate lanes of the permuted Keccak state one lane per handshake, forwards them as a byte-length-limited output stream, and marks the final lane with a byte-keep mask. Requests a further permutation each time a full rate block is consumed and output is still owed. Sits between the Keccak core's state readout and the SHAKE output port.

## Interface
Parameters:
- WIDTH, 32, width of the output byte-length counter
- LANES_IN_RATE, 17, rate lanes per block (17 = SHAKE256, 21 = SHAKE128)
- Lane width is `w` from keccak_pkg (64); `byte_delta = w/8` = 8.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; latches output_byte_size; ignored unless IDLE
- output_byte_size  input  WIDTH  requested output length in bytes
- lane_data  input  w  rate lane from state, byte 0 in bits [7:0]
- lane_valid  input  1  lane_data valid
- lane_ready  output  1  lane accepted when lane_valid && lane_ready
- perm_req  output  1  one-cycle pulse: run another permutation
- perm_done  input  1  one-cycle pulse: new state ready for readout
- dout  output  w  output lane, unused bytes forced to zero
- dout_keep  output  w/8  byte-valid mask, bit i covers dout[8i+7:8i]
- dout_valid  output  1  dout holds a word
- dout_ready  input  1  downstream accepts
- dout_last  output  1  dout is the final word
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after last word handshake (or zero-length start)

## Operation
- States: IDLE, STREAM, PERM, FLUSH.
- IDLE: start with size > 0 -> remaining <= size, lane_cnt <= 0, STREAM. start with size 0 -> done pulse next cycle, stay IDLE.
- STREAM: lane_ready = !dout_valid || dout_ready. On lane accept:
  - dout <= lane_data masked; dout_valid <= 1.
  - If remaining <= byte_delta: dout_keep <= (1 << remaining) - 1 (remaining = 8 -> all ones), bytes above masked to 0, dout_last <= 1, go FLUSH.
  - Else: dout_keep <= all ones, remaining <= remaining - 8, lane_cnt++.
  - If lane_cnt was LANES_IN_RATE-1 (non-final lane): lane_cnt <= 0, perm_req pulse, go PERM.
- PERM: lane_ready = 0; output register may still drain. perm_done -> STREAM.
- FLUSH: lane_ready = 0. On dout handshake: dout_valid, dout_last <= 0; done pulse; IDLE.
- No perm_req is issued when the final lane falls on a block boundary.
- Output register drains independently: dout_valid && dout_ready with no new lane clears dout_valid.
- perm_done outside PERM is ignored. start while busy is ignored.

## Timing
- Reset: state IDLE; lane_ready, perm_req, dout, dout_keep, dout_valid, dout_last, busy, done all 0; counters 0.
- Latency: lane accepted at edge t -> dout_valid from t+1. Throughput is 1 lane/cycle while dout_ready is held high.
- start at edge t -> busy and lane_ready high from t+1.
- perm_req is high in the cycle after the boundary lane is accepted. lane_ready is low from that cycle until the cycle after perm_done.
- done is high in the cycle after the final dout handshake. busy drops in the same cycle.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is issued.
- Downstream backpressure holds dout, dout_keep and dout_last stable while dout_valid && !dout_ready.

## Test plan
- Size 16, LANES_IN_RATE 17, dout_ready held 1 -> 2 words, keep 0xFF/0xFF, last on word 2, no perm_req, done 1 cycle after second handshake.
- Size 13 -> word 2 has keep 0x1F, bytes 5..7 zero, dout_last=1.
- Size 200 (SHAKE256) -> perm_req after lane 17, lane_ready low until perm_done, then 8 more words. Final keep 0xFF (200 = 25×8). Exactly one perm_req.
- Size 136 -> 17 words, last on word 17, no perm_req.
- Random dout_ready backpressure, size 300 -> outputs held stable while stalled, no lane lost or duplicated, byte count 300.
- Size 0 -> done pulse 1 cycle after start, no dout_valid. rst low mid-stream -> all outputs 0 at once, no done. start while busy -> ignored.
